// File: rtl/tree_adder_pkg.sv
// Shared types and helpers for the tree adder job scheduler.
// - state_e   : scheduler FSM states
// - acc_width : result width that holds a full job reduction without wrap
// - word_lo   : LSB position of leaf word k in a packed operand vector
package tree_adder_pkg;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

  // 2**n words of dw bits summed over up to 2**bw-1 beats.
  function automatic int acc_width(input int dw, input int n, input int bw);
    return dw + n + bw;
  endfunction

  function automatic int word_lo(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Shift register of valid bits matching a fixed-latency datapath.
// Ports:
//   clk, rst : clock, synchronous active-high clear
//   vld_in   : valid bit entering the datapath this cycle
//   vld_pipe : vld_pipe[k] is the valid that entered k+1 cycles ago
module valid_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  output logic [DEPTH-1:0] vld_pipe
);

  logic [DEPTH-1:0] pipe_q, pipe_d;

  if (DEPTH == 1) begin : g_one
    assign pipe_d = vld_in;
  end else begin : g_many
    assign pipe_d = {pipe_q[DEPTH-2:0], vld_in};
  end

  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign vld_pipe = pipe_q;

endmodule

// File: rtl/tree_adder_sched.sv
// Job-level sequencer for an external pipelined tree adder (latency N).
// Accepts a job of job_beats vectors, streams them to the adder, sums every
// returning adder result and presents one reduction per job.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   job_valid/job_ready/job_beats : job request handshake and length
//   in_valid/in_ready/in_data     : input beat stream (2**N packed words)
//   add_inps/add_en/add_sum       : adder operands, issue strobe, result
//   res_valid/res_ready/res_sum   : final result handshake
module tree_adder_sched
  import tree_adder_pkg::*;
#(
  parameter  int DATA_WIDTH = 4,
  parameter  int N          = 3,
  parameter  int BEAT_W     = 4,
  localparam int ACC_W      = acc_width(DATA_WIDTH, N, BEAT_W),
  localparam int IN_W       = DATA_WIDTH * (2 ** N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [BEAT_W-1:0]       job_beats,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic [IN_W-1:0]         add_inps,
  output logic                    add_en,
  input  logic [DATA_WIDTH+N-1:0] add_sum,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_W-1:0]        res_sum
);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              job_ready_q, job_ready_d;
  logic              in_ready_q, in_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [N-1:0]      infl;

  assign add_inps = in_data;
  assign add_en   = in_valid && in_ready_q;

  // Mirrors the adder pipeline: infl[N-1] marks the cycle add_sum belongs
  // to an issued beat. Cleared on reset so results of an aborted job are
  // never accumulated.
  valid_delay_line #(.DEPTH(N)) u_infl (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (add_en),
    .vld_pipe (infl)
  );

  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    acc_d       = acc_q;
    job_ready_d = job_ready_q;
    in_ready_d  = in_ready_q;
    res_valid_d = res_valid_q;
    if (infl[N-1]) acc_d = acc_q + ACC_W'(add_sum);
    case (state_q)
      IDLE: if (job_valid && job_ready_q) begin
        beats_d     = job_beats;
        acc_d       = '0;
        job_ready_d = 1'b0;
        if (job_beats == '0) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
        end else begin
          state_d    = FEED;
          in_ready_d = 1'b1;
        end
      end
      FEED: if (add_en) begin
        beats_d = beats_q - BEAT_W'(1);
        if (beats_q == BEAT_W'(1)) begin
          state_d    = DRAIN;
          in_ready_d = 1'b0;
        end
      end
      // Pipeline empty means the last sum was folded in on the prior edge.
      DRAIN: if (infl == '0) begin
        state_d     = DONE;
        res_valid_d = 1'b1;
      end
      DONE: if (res_ready) begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
        job_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beats_q     <= '0;
      acc_q       <= '0;
      job_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      acc_q       <= acc_d;
      job_ready_q <= job_ready_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign job_ready = job_ready_q;
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_sum   = acc_q;

endmodule

// File: doc/tree_adder_sched.md
Name: tree_adder_sched

Overview:
Job-level sequencer for the pipelined balanced tree adder (2**N leaves, DATA_WIDTH each, latency N).
- Accepts a job of job_beats input vectors and streams them into the adder with a valid/ready handshake.
- Tracks in-flight beats through the adder latency and accumulates each adder sum.
- Presents one final reduction result per job on a valid/ready output port.

Parameters:
DATA_WIDTH, 4, width of each leaf operand (unsigned)
N, 3, tree depth; 2**N operands per beat; adder latency N cycles
BEAT_W, 4, width of job_beats; max job length 2**BEAT_W-1 beats
ACC_W, DATA_WIDTH+N+BEAT_W, result width (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
job_valid  in  1  job request
job_ready  out  1  high when idle and able to accept a job
job_beats  in  BEAT_W  number of input beats in the job
in_valid  in  1  input beat valid
in_ready  out  1  scheduler accepts a beat
in_data  in  DATA_WIDTH*2**N  packed leaf operands, word k at [k*DATA_WIDTH +: DATA_WIDTH]
add_inps  out  DATA_WIDTH*2**N  operands to adder (equals in_data)
add_en  out  1  beat issued to adder this cycle
add_sum  in  DATA_WIDTH+N  adder result, valid N cycles after matching add_en
res_valid  out  1  final result valid
res_ready  in  1  consumer accepts result
res_sum  out  ACC_W  accumulated sum of all words of all beats

Behaviour:
- Reset: synchronous, active-high, on clk. Decided: one clock; reset synchronous and active-high.
- Reset values: state=IDLE, acc=0, beat counter=0, in-flight shift register=0, res_valid=0, in_ready=0, add_en=0. job_ready=1 on the first cycle after rst deasserts.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: job_ready=1.
  - On job_valid&&job_ready, latch job_beats and clear acc.
  - job_beats==0: go to DONE with res_sum=0.
  - Otherwise go to FEED.
- FEED: in_ready=1, job_ready=0.
  - add_inps=in_data (combinational); add_en=in_valid&&in_ready.
  - Each accepted beat decrements the counter and shifts a 1 into the N-deep in-flight register.
  - A cycle with in_valid=0 shifts in a 0.
  - Accepting the last beat moves to DRAIN the next cycle.
- Adder: free-running, no stall. add_sum is sampled in the cycle when in-flight bit N-1 is 1, and acc<=acc+add_sum (zero-extended) on that edge.
- DRAIN: in_ready=0. When the in-flight register is all zero, go to DONE.
- DONE: res_valid=1, res_sum=acc, stable until res_ready. On res_valid&&res_ready, go to IDLE.
- Latency: last beat accepted in cycle t → res_valid first high in cycle t+N+2.
- Width: unsigned arithmetic. ACC_W covers the worst case (2**N·(2**DATA_WIDTH-1)·(2**BEAT_W-1)), so no overflow or wrap.
- Job/result handshakes: job_valid outside IDLE is ignored, and job_ready stays 0 until the result is consumed. No overlap of jobs.
- Reset mid-job: the in-flight register is cleared, so stale add_sum values arriving afterwards are never accumulated. acc is cleared and no res_valid is produced for the aborted job.
- N is not special-cased; a valid configuration requires N≥1.

Decomposition:
- Package tree_adder_pkg holds:
  - the state enum (IDLE/FEED/DRAIN/DONE);
  - a function computing ACC_W from DATA_WIDTH, N, BEAT_W;
  - a packed-vector word-index helper.
- One sub-module: valid_delay_line (depth N, synchronous clear), reused for in-flight tracking.

Test Plan:
- DATA_WIDTH=4, N=3. job_beats=1, all eight words=15, in_valid held high → add_en high one cycle, res_sum=120, res_valid exactly N+2=5 cycles after beat accept.
- job_beats=3, beats of all 1s, all 2s, all 15s, back-to-back → res_sum=8+16+120=144; in_ready drops after the third beat.
- job_beats=4 with in_valid gaps (pattern 1,0,0,1,1,0,1), words=k (0..7, sum 28) → res_sum=112; no beat is lost or double-counted.
- job_beats=0 → DONE next cycle, res_sum=0, add_en never asserted.
- res_ready held low 10 cycles after res_valid → res_sum stable, job_ready=0, a new job_valid is ignored. Release res_ready → IDLE; the next job accepted gives a correct independent sum.
- rst asserted 2 cycles into a job_beats=3 job with beats in flight → all outputs reset, no res_valid. A following job_beats=1 job with words=15 yields exactly 120.
